// File: rtl/cpu_mem_if.sv
// CPU-to-memory request/acknowledge bus: the CPU holds a request until it sees
// a one-cycle ack carrying the read data and the out-of-range flag.
interface cpu_mem_if;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ack;
    logic [7:0] rdata;
    logic       err;

    modport master (output req, we, addr, wdata, input ack, rdata, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/cpu_mem_responder.sv
// Wait-state memory responder: latches a CPU request, waits WAIT_CYCLES, then
// completes it with a one-cycle ack. Storage is not reset and survives rst.
module cpu_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    cpu_mem_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t      state_r, state_nx_s;
    logic [3:0]  cnt_r, cnt_nx_s;
    logic        latch_s, go_ack_s;
    logic        we_r;
    logic [7:0]  addr_r, wdata_r;
    logic        acc_we_s;
    logic [7:0]  acc_addr_s, acc_wdata_s;
    logic        in_range_s;
    logic [AW-1:0] idx_s;
    logic        ack_r, err_r;
    logic [7:0]  rdata_r;
    logic [7:0]  mem_r [DEPTH];

    // State register, wait counter and latched request fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            addr_r  <= 8'h00;
            wdata_r <= 8'h00;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            if (latch_s) begin
                we_r    <= bus.we;
                addr_r  <= bus.addr;
                wdata_r <= bus.wdata;
            end
        end
    end

    // Next-state logic; go_ack_s marks the edge that enters ACK
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        latch_s    = 1'b0;
        go_ack_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req) begin
                    latch_s  = 1'b1;
                    cnt_nx_s = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_nx_s = ACK;
                        go_ack_s   = 1'b1;
                    end else begin
                        state_nx_s = WAIT;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_nx_s = ACK;
                    cnt_nx_s   = 4'd0;
                    go_ack_s   = 1'b1;
                end else begin
                    cnt_nx_s   = cnt_r - 4'd1;
                end
            end
            ACK:     state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // With zero wait states ACK is entered straight from IDLE, before the latch holds the request
    always_comb begin
        if (state_r == IDLE) begin
            acc_we_s    = bus.we;
            acc_addr_s  = bus.addr;
            acc_wdata_s = bus.wdata;
        end else begin
            acc_we_s    = we_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
        end
        in_range_s = ({1'b0, acc_addr_s} < 9'(DEPTH));
        idx_s      = acc_addr_s[AW-1:0];
    end

    // Storage write; gated by rst so an aborted transfer never lands
    always_ff @(posedge clk) begin
        if (go_ack_s && acc_we_s && in_range_s && !rst) begin
            mem_r[idx_s] <= acc_wdata_s;
        end
    end

    // Registered response: ack, err and rdata are non-zero only in the ack cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 8'h00;
        end else if (go_ack_s) begin
            ack_r   <= 1'b1;
            err_r   <= !in_range_s;
            rdata_r <= (in_range_s && !acc_we_s) ? mem_r[idx_s] : 8'h00;
        end else begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 8'h00;
        end
    end

    assign bus.ack   = ack_r;
    assign bus.err   = err_r;
    assign bus.rdata = rdata_r;
endmodule
